// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: turns the raw byte stream of a PS/2 keyboard into
// {ext, rel, code} key events, tracks held modifier keys and buffers events
// in a small first-word-fall-through FIFO with a sticky overflow flag.
module ps2_key_decoder #(
    parameter int TIMEOUT    = 100000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] mods,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [7:0] BYTE_EXT  = 8'hE0;
    localparam logic [7:0] BYTE_BRK  = 8'hF0;
    localparam logic [7:0] BYTE_ERR0 = 8'h00;
    localparam logic [7:0] BYTE_ERR1 = 8'hFF;

    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;
    localparam logic [7:0] CODE_CTRL    = 8'h14;
    localparam logic [7:0] CODE_ALT     = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } state_t;

    // Keyboard error / overrun markers abort any prefix in progress.
    function automatic logic is_error_byte(input logic [7:0] b);
        return (b == BYTE_ERR0) || (b == BYTE_ERR1);
    endfunction

    function automatic logic is_prefix_byte(input logic [7:0] b);
        return (b == BYTE_EXT) || (b == BYTE_BRK);
    endfunction

    // Advance a FIFO pointer, wrapping at the configured depth.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Apply one decoded event to the held-modifier flags {alt, ctrl, shift_r, shift_l}.
    // Shift keys only count in their plain form; ctrl/alt count in both forms.
    function automatic logic [3:0] update_mods(input logic [3:0] cur, input logic [9:0] ev);
        logic [3:0] nxt;
        logic       ext;
        logic       held;
        nxt  = cur;
        ext  = ev[9];
        held = ~ev[8];
        case (ev[7:0])
            CODE_SHIFT_L: begin
                if (!ext) begin
                    nxt[0] = held;
                end else begin
                    nxt[0] = cur[0];
                end
            end
            CODE_SHIFT_R: begin
                if (!ext) begin
                    nxt[1] = held;
                end else begin
                    nxt[1] = cur[1];
                end
            end
            CODE_CTRL: nxt[2] = held;
            CODE_ALT:  nxt[3] = held;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    state_t          state_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [9:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [3:0]      mods_r;
    logic            ovf_r;

    logic            emit_s;
    logic [9:0]      emit_word_s;
    logic            ext_s;
    logic            rel_s;
    logic            pop_s;
    logic            full_s;
    logic            push_ok_s;
    logic            drop_s;

    // Decode whether the byte in this cycle completes a key event, and its flags.
    always_comb begin
        emit_s      = 1'b0;
        emit_word_s = 10'h000;
        ext_s       = (state_r == ST_GOT_E0) || (state_r == ST_GOT_E0F0);
        rel_s       = (state_r == ST_GOT_F0) || (state_r == ST_GOT_E0F0);
        if (rx_valid && !is_error_byte(rx_data) && !is_prefix_byte(rx_data)) begin
            emit_s      = 1'b1;
            emit_word_s = {ext_s, rel_s, rx_data};
        end else begin
            emit_s      = 1'b0;
            emit_word_s = 10'h000;
        end
    end

    // Prefix parser with abandon timer: a stalled prefix falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
        end else if (rx_valid) begin
            tmo_cnt_r <= '0;
            if (is_error_byte(rx_data)) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rx_data == BYTE_EXT) begin
                            state_r <= ST_GOT_E0;
                        end else if (rx_data == BYTE_BRK) begin
                            state_r <= ST_GOT_F0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_GOT_E0: begin
                        if (rx_data == BYTE_EXT) begin
                            state_r <= ST_GOT_E0;
                        end else if (rx_data == BYTE_BRK) begin
                            state_r <= ST_GOT_E0F0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_GOT_F0: begin
                        if (rx_data == BYTE_BRK) begin
                            state_r <= ST_GOT_F0;
                        end else if (rx_data == BYTE_EXT) begin
                            state_r <= ST_GOT_E0F0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_GOT_E0F0: begin
                        if (is_prefix_byte(rx_data)) begin
                            state_r <= ST_GOT_E0F0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end else if (state_r == ST_IDLE) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    always_comb begin
        pop_s     = (count_r != '0) && ev_ready;
        full_s    = (count_r == CW'(FIFO_DEPTH));
        push_ok_s = emit_s && (!full_s || pop_s);
        drop_s    = emit_s && full_s && !pop_s;
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'h000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= emit_word_s;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    // Modifier tracking follows every decoded event, even ones the FIFO drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mods_r <= 4'h0;
        end else if (emit_s) begin
            mods_r <= update_mods(mods_r, emit_word_s);
        end
    end

    assign ev_valid = (count_r != '0);
    assign ev_data  = ev_valid ? mem_r[rd_ptr_r] : 10'h000;
    assign mods     = mods_r;
    assign ovf      = ovf_r;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameters: TIMEOUT, default 100000, prefix-abandon limit in clk cycles; FIFO_DEPTH, default 4, event FIFO entries (power of 2).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  received scan-code byte from the PS/2 receiver stage.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-006 ev_data  output  10  head event {ext, rel, code[7:0]}; ext = E0-prefixed, rel = break (F0-prefixed).
REQ-007 ev_valid  output  1  FIFO non-empty; ev_data valid.
REQ-008 ev_ready  input  1  consumer accepts head when ev_valid & ev_ready.
REQ-009 mods  output  4  {alt, ctrl, shift_r, shift_l} held-key flags.
REQ-010 ovf  output  1  sticky event-dropped flag.
REQ-011 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 Prefix parser SHALL be a 4-state FSM: IDLE, GOT_E0, GOT_F0, GOT_E0F0; it advances only on cycles with rx_valid=1.
REQ-013 IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other byte -> emit {0,0,byte}, stay IDLE.
REQ-014 GOT_E0: 0xE0 -> stay; 0xF0 -> GOT_E0F0; other -> emit {1,0,byte}, IDLE.
REQ-015 GOT_F0: 0xF0 -> stay; 0xE0 -> GOT_E0F0; other -> emit {0,1,byte}, IDLE.
REQ-016 GOT_E0F0: 0xE0/0xF0 -> stay; other -> emit {1,1,byte}, IDLE.
REQ-017 Bytes 0x00 and 0xFF (keyboard error/overrun) SHALL be discarded in any state, FSM -> IDLE, no emit.
REQ-018 Timeout counter SHALL clear on every rx_valid and in IDLE, increment each cycle otherwise; reaching TIMEOUT-1 without rx_valid forces IDLE next edge, no emit.
REQ-019 Emit SHALL write the event into the FIFO at the clock edge ending the rx_valid cycle; ev_valid/ev_data reflect it the next cycle (latency 1 when FIFO was empty).
REQ-020 FIFO SHALL be first-word-fall-through: ev_data always shows oldest entry; pop on ev_valid & ev_ready.
REQ-021 Push while full SHALL be accepted only if a pop occurs the same cycle; otherwise event dropped, FIFO unchanged, ovf set next edge.
REQ-022 Push and pop same cycle with FIFO non-full SHALL leave occupancy unchanged; pop on empty SHALL be ignored.
REQ-023 ovf_clr SHALL clear ovf; a drop in the same cycle as ovf_clr SHALL win (ovf=1).
REQ-024 mods SHALL update at the emit edge regardless of FIFO drop: code 0x12 non-ext -> shift_l, 0x59 non-ext -> shift_r, 0x14 ext or non-ext -> ctrl, 0x11 ext or non-ext -> alt; set on make (rel=0), clear on break (rel=1).
REQ-025 Pointers and counts SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-026 rst_n low SHALL immediately force FSM IDLE, timeout counter 0, FIFO empty (ev_valid=0), ev_data=10'h000, mods=4'h0, ovf=0.
REQ-027 Reset mid-prefix or with FIFO non-empty SHALL discard all partial and queued events.

Verification
REQ-028 Bytes 0x1C -> one event 10'h01C, ev_valid high the cycle after rx_valid; ev_ready=1 pops it, ev_valid low next cycle.
REQ-029 Bytes E0,F0,75 -> single event 10'h375; E0,75 -> 10'h275; F0,1C -> 10'h11C.
REQ-030 Bytes 12 then F0,12 -> mods=4'b0001 after first, 4'b0000 after break; E0,14 -> mods[2]=1.
REQ-031 ev_ready=0, five make bytes (default depth 4) -> 4 events retained in order, fifth dropped, ovf=1; ovf_clr -> ovf=0.
REQ-032 Byte F0 then TIMEOUT idle cycles, then 1C -> event 10'h01C (rel=0); byte E0 then FF then 1C -> 10'h01C.
REQ-033 FIFO full, push with simultaneous pop -> no drop, occupancy stays 4, order preserved; rst_n pulse mid-prefix -> all outputs at reset values.
